// File: rtl/exc_pkg.sv
// exc_pkg: shared types and constants for the exception controller slice.
//   exc_state_t       : controller states (IDLE, FLUSH, HANDLER, RETURN)
//   ES_NONE           : ESR value when nothing has been taken
//   ES_NOTINSTR       : ESR code reported for decoder NotAnInstr (source 1)
//   VEC_ADDR_DEFAULT  : default exception vector
// Optional feature macro used by importers: EXC_STATS_EN.
package exc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FLUSH   = 2'd1,
    HANDLER = 2'd2,
    RETURN  = 2'd3
  } exc_state_t;

  localparam int unsigned ES_NONE     = 0;
  localparam int unsigned ES_NOTINSTR = 2;

  localparam logic [63:0] VEC_ADDR_DEFAULT = 64'h0000_0000_0000_00D8;

endpackage

// File: rtl/exc_ctrl_if.sv
// exc_ctrl_if: core <-> exception controller bundle.
//   master : core side (drives exc_req, pc_i, eret_i; observes the rest)
//   slave  : controller side (drives redirect/target/flush/elr/esr/
//            in_handler/pending/spurious)
// With EXC_STATS_EN defined, taken_cnt_o carries one 8-bit saturating
// take counter per source (source i in bits [8*i+7:8*i]).
interface exc_ctrl_if #(
  parameter int N_SRC = 4,
  parameter int PC_W  = 64,
  parameter int ES_W  = 4
);

  logic [N_SRC-1:0] exc_req;
  logic [PC_W-1:0]  pc_i;
  logic             eret_i;
  logic             redirect_o;
  logic [PC_W-1:0]  target_o;
  logic             flush_o;
  logic [PC_W-1:0]  elr_o;
  logic [ES_W-1:0]  esr_o;
  logic             in_handler_o;
  logic [N_SRC-1:0] pending_o;
  logic             spurious_o;
`ifdef EXC_STATS_EN
  logic [N_SRC*8-1:0] taken_cnt_o;

  modport master (
    output exc_req, pc_i, eret_i,
    input  redirect_o, target_o, flush_o, elr_o, esr_o,
           in_handler_o, pending_o, spurious_o, taken_cnt_o
  );

  modport slave (
    input  exc_req, pc_i, eret_i,
    output redirect_o, target_o, flush_o, elr_o, esr_o,
           in_handler_o, pending_o, spurious_o, taken_cnt_o
  );
`else
  modport master (
    output exc_req, pc_i, eret_i,
    input  redirect_o, target_o, flush_o, elr_o, esr_o,
           in_handler_o, pending_o, spurious_o
  );

  modport slave (
    input  exc_req, pc_i, eret_i,
    output redirect_o, target_o, flush_o, elr_o, esr_o,
           in_handler_o, pending_o, spurious_o
  );
`endif

endinterface

// File: rtl/exc_ctrl_prio_enc.sv
// prio_enc: fixed-priority encoder, lowest set index wins. Combinational.
//   req    in  N       request vector
//   vld    out 1       any request set
//   onehot out N       one-hot of the winning bit (0 when none)
//   idx    out IDX_W   index of the winning bit (0 when none)
module prio_enc #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  output logic             vld,
  output logic [N-1:0]     onehot,
  output logic [IDX_W-1:0] idx
);

  assign vld = |req;

  // Isolate the lowest set bit with two's-complement masking.
  assign onehot = req & (~req + N'(1));

  // Scan downward so the lowest set bit is the last one written.
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/exc_ctrl.sv
// exc_ctrl: exception controller for the single-cycle LEGv8 core.
//   clk    in  clock, rising edge
//   reset  in  synchronous, active-high; clears all state
//   bus    slave modport of exc_ctrl_if:
//     exc_req/pc_i/eret_i in; redirect_o/target_o/flush_o/elr_o/esr_o/
//     in_handler_o/pending_o/spurious_o out (all registered)
// Source 0 has highest priority; source i reports ESR code i+1, so the
// decoder's NotAnInstr on source 1 reports 2.
// Optional: define EXC_STATS_EN for per-source 8-bit saturating take
// counters on bus.taken_cnt_o.
module exc_ctrl
  import exc_pkg::*;
#(
  parameter int          N_SRC     = 4,
  parameter int          PC_W      = 64,
  parameter int          ES_W      = 4,
  parameter logic [63:0] VEC_ADDR  = VEC_ADDR_DEFAULT,
  parameter int          FLUSH_CYC = 2
) (
  input logic     clk,
  input logic     reset,
  exc_ctrl_if.slave bus
);

  localparam int              IDX_W      = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam logic [PC_W-1:0] VEC        = PC_W'(VEC_ADDR);
  localparam logic [3:0]      FLUSH_LOAD = 4'(FLUSH_CYC - 1);

  exc_state_t       state;
  logic [N_SRC-1:0] pending;
  logic [N_SRC-1:0] eff;
  logic [N_SRC-1:0] take_oh;
  logic [N_SRC-1:0] take_mask;
  logic             take_vld;
  logic [IDX_W-1:0] take_idx;
  logic [3:0]       flush_cnt;
  logic             redirect_r;
  logic [PC_W-1:0]  target_r;
  logic             flush_r;
  logic [PC_W-1:0]  elr_r;
  logic [ES_W-1:0]  esr_r;
  logic             in_handler_r;
  logic             spurious_r;

  // Requests in their first cycle are eligible together with latched ones.
  assign eff = pending | bus.exc_req;

  prio_enc #(.N(N_SRC), .IDX_W(IDX_W)) u_prio (
    .req    (eff),
    .vld    (take_vld),
    .onehot (take_oh),
    .idx    (take_idx)
  );

  // Only IDLE takes; elsewhere requests just accumulate.
  assign take_mask = (state == IDLE) ? take_oh : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      pending      <= '0;
      flush_cnt    <= '0;
      redirect_r   <= 1'b0;
      target_r     <= '0;
      flush_r      <= 1'b0;
      elr_r        <= '0;
      esr_r        <= ES_W'(ES_NONE);
      in_handler_r <= 1'b0;
      spurious_r   <= 1'b0;
    end else begin
      pending    <= eff & ~take_mask;
      redirect_r <= 1'b0;
      target_r   <= '0;
      spurious_r <= 1'b0;
      case (state)
        IDLE: begin
          if (take_vld) begin
            elr_r      <= bus.pc_i;
            esr_r      <= ES_W'(take_idx) + ES_W'(1);
            redirect_r <= 1'b1;
            target_r   <= VEC;
            flush_r    <= 1'b1;
            flush_cnt  <= FLUSH_LOAD;
            state      <= FLUSH;
          end else if (bus.eret_i) begin
            spurious_r <= 1'b1;
          end
        end
        // FLUSH and RETURN share the flush countdown; only the exit differs.
        FLUSH, RETURN: begin
          if (flush_cnt == 4'd0) begin
            flush_r <= 1'b0;
            if (state == FLUSH) begin
              state        <= HANDLER;
              in_handler_r <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end else begin
            flush_cnt <= flush_cnt - 4'd1;
          end
        end
        HANDLER: begin
          if (bus.eret_i) begin
            in_handler_r <= 1'b0;
            redirect_r   <= 1'b1;
            target_r     <= elr_r;
            flush_r      <= 1'b1;
            flush_cnt    <= FLUSH_LOAD;
            state        <= RETURN;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.redirect_o   = redirect_r;
  assign bus.target_o     = target_r;
  assign bus.flush_o      = flush_r;
  assign bus.elr_o        = elr_r;
  assign bus.esr_o        = esr_r;
  assign bus.in_handler_o = in_handler_r;
  assign bus.pending_o    = pending;
  assign bus.spurious_o   = spurious_r;

`ifdef EXC_STATS_EN
  logic [7:0] taken_cnt [N_SRC];

  always_ff @(posedge clk) begin
    for (int i = 0; i < N_SRC; i++) begin
      if (reset) begin
        taken_cnt[i] <= '0;
      end else if (take_mask[i] && (taken_cnt[i] != 8'hFF)) begin
        taken_cnt[i] <= taken_cnt[i] + 8'd1;
      end
    end
  end

  for (genvar g = 0; g < N_SRC; g++) begin : g_cnt
    assign bus.taken_cnt_o[g*8 +: 8] = taken_cnt[g];
  end
`endif

endmodule

// File: tb/tb_exc_ctrl.sv
module tb_exc_ctrl;

  localparam int          N  = 4;
  localparam int          F  = 2;
  localparam logic [63:0] VA = 64'hD8;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  exc_ctrl_if #(.N_SRC(N), .PC_W(64), .ES_W(4)) bus ();

  exc_ctrl #(.N_SRC(N), .PC_W(64), .ES_W(4), .VEC_ADDR(VA), .FLUSH_CYC(F)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: phase of the exception flow plus cycles spent in it.
  // phase 0 normal, 1 vectoring, 2 in handler, 3 returning.
  int          ph;
  int          age;
  logic [3:0]  m_pend;
  logic [63:0] m_elr;
  logic [3:0]  m_esr;
  logic        e_redirect, e_flush, e_inh, e_spur;
  logic [63:0] e_target;
  int          m_cnt [N];

  task automatic model_reset();
    ph = 0; age = 0; m_pend = '0; m_elr = '0; m_esr = '0;
    e_redirect = 0; e_flush = 0; e_inh = 0; e_spur = 0; e_target = '0;
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
  endtask

  task automatic model_update(input logic [3:0] req, input logic [63:0] pc, input logic er);
    logic [3:0] all;
    int k;
    all = m_pend | req;
    e_spur = 0;
    if (ph == 0) begin
      if (all != 0) begin
        k = N;
        for (int i = N - 1; i >= 0; i--) if (all[i]) k = i;
        m_elr  = pc;
        m_esr  = 4'(k + 1);
        m_pend = all & ~(4'b0001 << k);
        if (m_cnt[k] < 255) m_cnt[k]++;
        ph = 1; age = 1;
      end else begin
        m_pend = all;
        if (er) e_spur = 1;
      end
    end else if (ph == 1 || ph == 3) begin
      m_pend = all;
      if (age == F) begin
        ph  = (ph == 1) ? 2 : 0;
        age = 0;
      end else begin
        age++;
      end
    end else begin
      m_pend = all;
      if (er) begin ph = 3; age = 1; end
    end
    e_redirect = (ph == 1 || ph == 3) && age == 1;
    e_target   = !e_redirect ? 64'd0 : (ph == 1) ? VA : m_elr;
    e_flush    = (ph == 1 || ph == 3);
    e_inh      = (ph == 2);
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".redirect"}, 64'(bus.redirect_o), 64'(e_redirect));
    chk({tag, ".target"},   bus.target_o, e_target);
    chk({tag, ".flush"},    64'(bus.flush_o), 64'(e_flush));
    chk({tag, ".elr"},      bus.elr_o, m_elr);
    chk({tag, ".esr"},      64'(bus.esr_o), 64'(m_esr));
    chk({tag, ".inh"},      64'(bus.in_handler_o), 64'(e_inh));
    chk({tag, ".pending"},  64'(bus.pending_o), 64'(m_pend));
    chk({tag, ".spur"},     64'(bus.spurious_o), 64'(e_spur));
`ifdef EXC_STATS_EN
    for (int i = 0; i < N; i++)
      chk({tag, ".cnt"}, 64'(bus.taken_cnt_o[i*8 +: 8]), 64'(m_cnt[i]));
`endif
  endtask

  task automatic step(input string tag, input logic rst, input logic [3:0] req,
                      input logic [63:0] pc, input logic er);
    reset       = rst;
    bus.exc_req = req;
    bus.pc_i    = pc;
    bus.eret_i  = er;
    @(posedge clk);
    #1;
    if (rst) model_reset();
    else     model_update(req, pc, er);
    check_all(tag);
  endtask

  initial begin
    model_reset();
    reset = 1'b1; bus.exc_req = '0; bus.pc_i = '0; bus.eret_i = 1'b0;
    @(negedge clk);

    // 1: reset dominates active requests
    for (int i = 0; i < 3; i++) step("t1", 1, 4'b1111, 64'h1234, 1);
    step("t1_idle", 0, 4'b0000, 64'h0, 0);

    // 2: NotAnInstr on source 1
    step("t2_take", 0, 4'b0010, 64'h40, 0);
    chk("t2_redirect", 64'(bus.redirect_o), 64'd1);
    chk("t2_target", bus.target_o, 64'hD8);
    chk("t2_esr", 64'(bus.esr_o), 64'(exc_pkg::ES_NOTINSTR));
    chk("t2_elr", bus.elr_o, 64'h40);
    step("t2_f2", 0, 0, 64'h44, 0);
    chk("t2_flush2", 64'(bus.flush_o), 64'd1);
    step("t2_h", 0, 0, 64'h48, 0);
    chk("t2_inh", 64'(bus.in_handler_o), 64'd1);
    chk("t2_noflush", 64'(bus.flush_o), 64'd0);
    step("t2_eret", 0, 0, 64'hDC, 1);
    chk("t2_rtgt", bus.target_o, 64'h40);
    step("t2_r2", 0, 0, 64'hE0, 0);
    step("t2_idle", 0, 0, 64'h40, 0);

    // 3: two simultaneous requests
    step("t3_take", 0, 4'b1010, 64'h80, 0);
    chk("t3_pend", 64'(bus.pending_o), 64'b1000);
    chk("t3_esr", 64'(bus.esr_o), 64'b0010);
    step("t3_f2", 0, 0, 64'h84, 0);
    step("t3_h", 0, 0, 64'h88, 0);
    step("t3_eret", 0, 0, 64'hD8, 1);
    step("t3_r2", 0, 0, 64'hDC, 0);
    step("t3_idle", 0, 0, 64'h80, 0);
    step("t3_take2", 0, 0, 64'h90, 0);
    chk("t3_esr2", 64'(bus.esr_o), 64'b0100);
    chk("t3_redir2", 64'(bus.redirect_o), 64'd1);

    // 4: ERET wins over a same-cycle request
    step("t4_f2", 0, 0, 64'h94, 0);
    step("t4_h", 0, 0, 64'h98, 0);
    step("t4_eret", 0, 4'b0001, 64'hD8, 1);
    chk("t4_rtgt", bus.target_o, 64'h90);
    chk("t4_pend", 64'(bus.pending_o), 64'b0001);
    step("t4_r2", 0, 0, 64'hDC, 0);
    step("t4_idle", 0, 0, 64'h90, 0);
    step("t4_take", 0, 0, 64'hA0, 0);
    chk("t4_esr", 64'(bus.esr_o), 64'b0001);
    step("t4_f2b", 0, 0, 64'hA4, 0);
    step("t4_hb", 0, 0, 64'hA8, 0);
    step("t4_eretb", 0, 0, 64'hD8, 1);
    step("t4_r2b", 0, 0, 64'hDC, 0);
    step("t4_idleb", 0, 0, 64'hA0, 0);

    // 5: spurious ERET
    step("t5_spur", 0, 0, 64'hB0, 1);
    chk("t5_spur", 64'(bus.spurious_o), 64'd1);
    chk("t5_noredir", 64'(bus.redirect_o), 64'd0);
    step("t5_after", 0, 0, 64'hB4, 0);

    // 6: reset during the second flush cycle
    step("t6_take", 0, 4'b0011, 64'hC0, 0);
    step("t6_f2", 0, 0, 64'hC4, 0);
    step("t6_rst", 1, 0, 64'hC8, 0);
    chk("t6_flush", 64'(bus.flush_o), 64'd0);
    chk("t6_pend", 64'(bus.pending_o), 64'd0);
    step("t6_idle", 0, 0, 64'hCC, 0);

`ifdef EXC_STATS_EN
    for (int n = 0; n < 300; n++) begin
      step("st_take", 0, 4'b0001, 64'(n), 0);
      step("st_f2", 0, 0, 64'h0, 0);
      step("st_h", 0, 0, 64'h0, 0);
      step("st_eret", 0, 0, 64'h0, 1);
      step("st_r2", 0, 0, 64'h0, 0);
      step("st_idle", 0, 0, 64'h0, 0);
    end
    chk("st_sat", 64'(bus.taken_cnt_o[7:0]), 64'd255);
`endif

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      logic [3:0]  rq;
      logic        er;
      logic        rs;
      rq = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0000;
      er = ($urandom_range(0, 3) == 0);
      rs = ($urandom_range(0, 99) == 0);
      step("rnd", rs, rq, {$urandom, $urandom}, er);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/exc_ctrl.md
Name: exc_ctrl

Overview:
- Parametrised exception/interrupt controller for the single-cycle LEGv8 core with exceptions.
- Collects N_SRC synchronous exception requests and selects one by fixed priority. Decoder NotAnInstr is wired to source 1.
- Captures ELR/ESR, drives PC redirect to the exception vector plus a pipeline flush, and masks further exceptions while in the handler.
- Services ERET by redirecting to the saved ELR. Sits between the decoder/datapath and the PC-select mux.

Parameters:
- N_SRC, 4, number of exception sources; bit 0 has highest priority.
- PC_W, 64, PC/ELR width.
- ES_W, 4, ESR width; source i reports code i+1 (NotAnInstr on src1 gives 4'b0010).
- VEC_ADDR, 64'h0000_0000_0000_00D8, exception vector, truncated to PC_W.
- FLUSH_CYC, 2, cycles flush_o is held per redirect; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  reset, synchronous, active-high.
- exc_req  in  N_SRC  one-cycle or level exception requests.
- pc_i  in  PC_W  PC of the instruction in decode this cycle.
- eret_i  in  1  decoder ERet.
- redirect_o  out  1  one-cycle pulse: PC mux takes target_o.
- target_o  out  PC_W  redirect target.
- flush_o  out  1  squash the in-flight instruction / writes.
- elr_o  out  PC_W  saved return address.
- esr_o  out  ES_W  saved exception status (MRS source).
- in_handler_o  out  1  high while in HANDLER.
- pending_o  out  N_SRC  latched, not-yet-taken requests.
- spurious_o  out  1  one-cycle pulse on ERET outside the handler.

Behaviour:
- Reset (synchronous, wins over everything): state IDLE, all outputs 0, pending 0, elr 0, esr 0, flush counter 0. Reset mid-FLUSH or mid-RETURN aborts it with no redirect.
- Pending register:
  - pending <= (pending | exc_req) & ~take_mask.
  - take_mask is the one-hot bit being taken this cycle.
  - A request asserted in the same cycle it is taken is not re-latched.
- eff = pending | exc_req; priority encoder picks the lowest set index.
- IDLE:
  - If eff != 0: elr <= pc_i, esr <= idx+1, clear that bit, go FLUSH.
  - Otherwise, if eret_i: pulse spurious_o, stay in IDLE.
  - Zero-latency take: the registered outputs change on the next edge.
- FLUSH:
  - First cycle: redirect_o=1, target_o=VEC_ADDR.
  - flush_o=1 for exactly FLUSH_CYC cycles (down-counter), then go HANDLER.
  - eret_i is ignored during FLUSH.
- HANDLER:
  - in_handler_o=1; new requests only accumulate in pending (masked).
  - eret_i moves to RETURN. If a request arrives in the same cycle, ERET wins and the request is latched as pending.
- RETURN:
  - First cycle: redirect_o=1, target_o=elr_o; flush_o for FLUSH_CYC cycles, then IDLE.
  - elr/esr are held until the next take.
  - Pending requests are taken from IDLE on the cycle after IDLE is entered.
- target_o is 0 when redirect_o=0. esr_o and elr_o are stable outside a take edge.
- Multiple simultaneous requests: one per handler entry. The rest stay pending; no requests are lost.

Optional Feature:
- EXC_STATS_EN defined:
  - Adds output taken_cnt_o [N_SRC*8], one 8-bit saturating counter per source.
  - A counter increments on each take of that source and sticks at 255.
  - Counters are cleared by reset.
- Not defined: the port is absent and no counters are synthesised.

Decomposition:
- exc_pkg holds:
  - enum exc_state_t {IDLE, FLUSH, HANDLER, RETURN};
  - ES_W-independent code constants ES_NONE=0, ES_NOTINSTR=2;
  - default VEC_ADDR.
- Sub-module prio_enc #(N): input vector -> valid + one-hot + index, lowest index wins. Purely combinational; reused by a later interrupt extension.

Test Plan:
1. Reset with exc_req=4'b1111 -> all outputs 0; exc_req ignored while reset=1.
2. pc_i=0x40, exc_req=4'b0010 for 1 cycle:
   - next cycle redirect_o=1, target_o=0xD8, esr_o=4'b0010, elr_o=0x40;
   - flush_o high 2 cycles, then in_handler_o=1.
3. exc_req=4'b1010 in same cycle:
   - src1 taken first (esr=0010), pending_o=4'b1000.
   - After eret_i: redirect to elr, then src3 taken with esr=4'b0100.
4. In HANDLER, eret_i with exc_req=4'b0001 in the same cycle:
   - RETURN entered, target_o=elr_o, pending_o=0001;
   - handler re-entered with esr=0001 after return.
5. eret_i in IDLE with no requests -> spurious_o pulse, no redirect_o, no state change.
6. Reset asserted in second FLUSH cycle -> next cycle IDLE, flush_o=0, pending_o=0. With EXC_STATS_EN: counters=0, and 300 takes of src0 -> count 255.
